es_muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the execute stage. It replaces the fixed 32-bit divider and its `enable`/`complete` strobes with a valid/ready request and response pair. It adds multiply (low and high) modes, fast paths for divide-by-zero and signed overflow, and a flush input. The execute stage holds `es_ready_go` low until the response handshake completes.

---
 rtl/es_muldiv_pkg.sv | 34 +++
 rtl/es_muldiv_core.sv | 59 +++++
 rtl/es_muldiv_unit.sv | 116 +++++++++++
 tb/tb_es_muldiv_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/es_muldiv_pkg.sv
// Shared encodings and op classification helpers for the execute-stage
// multiply/divide unit.
package es_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL   = 3'd0,
    OP_MULH  = 3'd1,
    OP_MULHU = 3'd2,
    OP_DIV   = 3'd3,
    OP_MOD   = 3'd4,
    OP_DIVU  = 3'd5,
    OP_MODU  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  function automatic logic is_div_op(input md_op_e op);
    return (op == OP_DIV) || (op == OP_MOD) || (op == OP_DIVU) || (op == OP_MODU);
  endfunction

  function automatic logic is_quot_op(input md_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input md_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/es_muldiv_core.sv
// One-bit-per-cycle iteration engine: shared shift register, adder/subtractor
// and iteration counter used by both shift-add multiply and restoring divide.
module es_muldiv_core import es_muldiv_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 load,
  input  logic                 step,
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     opa,
  input  logic [WIDTH-1:0]     opb,
  output logic [2*WIDTH-1:0]   acc_next,
  output logic                 last
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   m;
  logic [CW-1:0]      cnt;
  logic               div_mode;
  logic [WIDTH:0]     add_a;
  logic [WIDTH:0]     add_b;
  logic [WIDTH:0]     sum;

  // Divide: trial-subtract divisor from {rem, next dividend bit}.
  // Multiply: conditionally add multiplicand to the high half, then shift right.
  always_comb begin
    if (div_mode) begin
      add_a = acc[2*WIDTH-1:WIDTH-1];
      add_b = ~{1'b0, m};
    end else begin
      add_a = {1'b0, acc[2*WIDTH-1:WIDTH]};
      add_b = acc[0] ? {1'b0, m} : '0;
    end
    sum = add_a + add_b + {{WIDTH{1'b0}}, div_mode};
    if (div_mode) begin
      if (!sum[WIDTH]) acc_next = {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else             acc_next = {acc[2*WIDTH-2:WIDTH-1], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      acc      <= {{WIDTH{1'b0}}, (is_div ? opa : opb)};
      m        <= is_div ? opb : opa;
      div_mode <= is_div;
      cnt      <= CW'(WIDTH);
    end else if (step) begin
      acc <= acc_next;
      cnt <= cnt - CW'(1);
    end
  end

  assign last = (cnt == CW'(1));

endmodule

// File: rtl/es_muldiv_unit.sv
// Execute-stage iterative multiply/divide unit with valid/ready request and
// response, divide fast paths and flush.
module es_muldiv_unit import es_muldiv_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_src1,
  input  logic [WIDTH-1:0] req_src2,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  md_state_e          state, state_next;
  md_op_e             op_in, op_q;
  logic               neg_a_q, neg_res_q;
  logic               accept, s1_neg, s2_neg, div0, ovf, fast, last;
  logic [WIDTH-1:0]   mag1, mag2, fast_result, calc_result;
  logic [2*WIDTH-1:0] acc_next, prod_s;

  assign req_ready  = (state == ST_IDLE) && !flush;
  assign resp_valid = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);
  assign accept     = req_valid && req_ready;

  // Request decode: reserved op folds into MUL, signed ops work on magnitudes.
  assign op_in  = (req_op == OP_RSVD) ? OP_MUL : md_op_e'(req_op);
  assign s1_neg = is_signed_op(op_in) && req_src1[WIDTH-1];
  assign s2_neg = is_signed_op(op_in) && req_src2[WIDTH-1];
  assign mag1   = cneg(req_src1, s1_neg);
  assign mag2   = cneg(req_src2, s2_neg);

  assign div0 = is_div_op(op_in) && (req_src2 == '0);
  assign ovf  = ((op_in == OP_DIV) || (op_in == OP_MOD)) &&
                (req_src1 == MIN_NEG) && (req_src2 == '1);
  assign fast = div0 || ovf;

  always_comb begin
    fast_result = '0;
    if (div0)     fast_result = is_quot_op(op_in) ? '1 : req_src1;
    else if (ovf) fast_result = (op_in == OP_DIV) ? MIN_NEG : '0;
  end

  es_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .load     (accept && !fast),
    .step     (state == ST_CALC),
    .is_div   (is_div_op(op_in)),
    .opa      (mag1),
    .opb      (mag2),
    .acc_next (acc_next),
    .last     (last)
  );

  // Sign post-processing on the final iteration's value.
  assign prod_s = cneg2(acc_next, neg_res_q);

  always_comb begin
    case (op_q)
      OP_MULH:          calc_result = prod_s[2*WIDTH-1:WIDTH];
      OP_MULHU:         calc_result = acc_next[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:  calc_result = cneg(acc_next[WIDTH-1:0], neg_res_q);
      OP_MOD, OP_MODU:  calc_result = cneg(acc_next[2*WIDTH-1:WIDTH], neg_a_q);
      default:          calc_result = acc_next[WIDTH-1:0];
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept)     state_next = fast ? ST_DONE : ST_CALC;
      ST_CALC: if (last)       state_next = ST_DONE;
      ST_DONE: if (resp_ready) state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      resp_result <= '0;
    end else begin
      state <= state_next;
      if (accept && fast)
        resp_result <= fast_result;
      else if ((state == ST_CALC) && last && !flush)
        resp_result <= calc_result;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q      <= op_in;
      neg_a_q   <= s1_neg;
      neg_res_q <= s1_neg ^ s2_neg;
    end
  end

endmodule

// File: tb/tb_es_muldiv_unit.sv
// Randomized and directed bench for es_muldiv_unit at WIDTH=32.
module tb_es_muldiv_unit;

  localparam logic [31:0] MINV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, flush, resp_valid, resp_ready, busy;
  logic [2:0]  req_op;
  logic [31:0] req_src1, req_src2, resp_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  es_muldiv_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_src1    (req_src1),
    .req_src2    (req_src2),
    .flush       (flush),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .busy        (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic ref_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic is_div;
    is_div = (op >= 3'd3) && (op <= 3'd6);
    return is_div && ((b == 32'd0) ||
           (((op == 3'd3) || (op == 3'd4)) && (a == MINV) && (b == 32'hFFFF_FFFF)));
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sp, sq;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = {32'd0, a} * {32'd0, b};
    sp = sa * sb;
    case (op)
      3'd1: return sp[63:32];
      3'd2: return up[63:32];
      3'd3: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
        sq = sa / sb;
        return sq[31:0];
      end
      3'd4: begin
        if (b == 32'd0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 32'd0;
        sq = sa % sb;
        return sq[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 32'd0) ? a : a % b;
      default: return up[31:0];
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return MINV;
      4: return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, then check latency, result, stability under stall and handshake.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall, input string tag);
    logic [31:0] expv;
    int exp_lat, lat;
    expv    = ref_result(op, a, b);
    exp_lat = ref_fast(op, a, b) ? 1 : 33;
    @(negedge clk);
    check_eq({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 3'($urandom); req_src1 = $urandom; req_src2 = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 100);
    check_eq({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, ".result"}, resp_result, expv);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq({tag, ".stall_valid"}, 32'(resp_valid), 32'd1);
      check_eq({tag, ".stall_result"}, resp_result, expv);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check_eq({tag, ".post_valid"}, 32'(resp_valid), 32'd0);
    check_eq({tag, ".post_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    reset = 1'b1; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    req_op = 3'd0; req_src1 = '0; req_src2 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("reset.resp_valid", 32'(resp_valid), 32'd0);
    check_eq("reset.busy", 32'(busy), 32'd0);
    check_eq("reset.resp_result", resp_result, 32'd0);
    check_eq("reset.req_ready", 32'(req_ready), 32'd1);

    run_op(3'd5, 32'd100, 32'd7, 0, "divu_100_7");
    run_op(3'd6, 32'd100, 32'd7, 1, "modu_100_7");
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0, "div_neg7_2");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, "mod_neg7_2");
    run_op(3'd5, 32'd5, 32'd0, 0, "divu_by0");
    run_op(3'd6, 32'd5, 32'd0, 0, "modu_by0");
    run_op(3'd3, MINV, 32'hFFFF_FFFF, 0, "div_ovf");
    run_op(3'd4, MINV, 32'hFFFF_FFFF, 0, "mod_ovf");
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul_ones");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulh_ones");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu_ones");
    run_op(3'd0, 32'h0001_0000, 32'h0001_0000, 0, "mul_2p16");
    run_op(3'd2, 32'h0001_0000, 32'h0001_0000, 0, "mulhu_2p16");
    run_op(3'd7, 32'd12345, 32'd678, 0, "rsvd_as_mul");
    run_op(3'd5, 32'd1000, 32'd33, 5, "backpressure");

    // Flush in the tenth CALC cycle.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd5; req_src1 = 32'd100; req_src2 = 32'd7;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("flush_calc.busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check_eq("flush_calc.resp_valid", 32'(resp_valid), 32'd0);
    check_eq("flush_calc.req_ready", 32'(req_ready), 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    check_eq("flush_calc.no_stale", 32'(seen), 32'd0);

    // Flush with a request in IDLE: not accepted.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_src1 = 32'd3; req_src2 = 32'd4; flush = 1'b1;
    #1 check_eq("flush_idle.req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1 req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check_eq("flush_idle.busy", 32'(busy), 32'd0);

    // Flush colliding with the response handshake drops the result.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd5; req_src1 = 32'd9; req_src2 = 32'd0;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_done.resp_valid", 32'(resp_valid), 32'd1);
    flush = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1 flush = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
    check_eq("flush_done.dropped", 32'(resp_valid), 32'd0);
    check_eq("flush_done.req_ready", 32'(req_ready), 32'd1);

    // Reset mid-operation clears state and result.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd2; req_src1 = 32'hDEAD_BEEF; req_src2 = 32'h1234_5678;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_eq("reset_mid.resp_valid", 32'(resp_valid), 32'd0);
    check_eq("reset_mid.busy", 32'(busy), 32'd0);
    check_eq("reset_mid.resp_result", resp_result, 32'd0);

    for (int n = 0; n < 150; n++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      run_op(op, a, b, $urandom_range(0, 3), $sformatf("rand%0d_op%0d", n, op));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
